// File: rtl/freq_div_ctrl.sv
// Programmable clock-divider sequencer: owns the divide ratio, runs/stops clk_out and tick.
// Optional FREQ_DIV_CTRL_CNT_EN adds a 16-bit period counter output (period_cnt).
module freq_div_ctrl #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
`ifdef FREQ_DIV_CTRL_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_divAct;
  logic             r_pend;
  logic [WIDTH-1:0] r_pendVal;
  logic             r_cfgErr;
  logic             r_clkOut;
  logic             r_tick;
  logic             r_busy;

  logic [1:0]       w_state;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_divAct;
  logic             w_pend;
  logic [WIDTH-1:0] w_pendVal;
  logic             w_accept;
  logic             w_bad;
  logic             w_boundary;
  logic [WIDTH:0]   w_hiLen;

  assign w_accept   = cfg_valid & ~r_pend;
  assign w_bad      = (cfg_div < WIDTH'(2));
  assign w_boundary = (r_cnt == r_divAct - WIDTH'(1));

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_divAct  = r_divAct;
    w_pend    = r_pend;
    w_pendVal = r_pendVal;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (w_accept && !w_bad) w_divAct = cfg_div;
        if (en) w_state = RUN;
      end
      RUN: begin
        if (w_boundary) begin
          if (en) begin
            w_cnt = '0;
            if (r_pend) begin
              w_divAct = r_pendVal;
              w_pend   = 1'b0;
            end
          end else begin
            w_state = STOP;
          end
        end else begin
          w_cnt = r_cnt + WIDTH'(1);
        end
        // A ratio accepted mid-period waits for the next boundary
        if (w_accept && !w_bad) begin
          w_pend    = 1'b1;
          w_pendVal = cfg_div;
        end
      end
      STOP: begin
        w_state = IDLE;
        w_cnt   = '0;
        if (r_pend) begin
          w_divAct = r_pendVal;
          w_pend   = 1'b0;
        end
        if (w_accept && !w_bad) w_divAct = cfg_div;
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the new counter
  assign w_hiLen = ({1'b0, w_divAct} + (WIDTH+1)'(1)) >> 1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_divAct  <= WIDTH'(DEFAULT_DIV);
      r_pend    <= 1'b0;
      r_pendVal <= '0;
      r_cfgErr  <= 1'b0;
      r_clkOut  <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_divAct  <= w_divAct;
      r_pend    <= w_pend;
      r_pendVal <= w_pendVal;
      r_cfgErr  <= w_accept & w_bad;
      r_clkOut  <= (w_state == RUN) && ({1'b0, w_cnt} < w_hiLen);
      r_tick    <= (w_state == RUN) && (w_cnt == '0);
      r_busy    <= (w_state != IDLE);
    end
  end

`ifdef FREQ_DIV_CTRL_CNT_EN
  logic [15:0] r_periodCnt;

  always_ff @(posedge clk_in) begin
    if (rst) r_periodCnt <= '0;
    else if (r_tick) r_periodCnt <= r_periodCnt + 16'd1;
  end

  assign period_cnt = r_periodCnt;
`endif

  assign cfg_ready = ~r_pend;
  assign cfg_err   = r_cfgErr;
  assign clk_out   = r_clkOut;
  assign tick      = r_tick;
  assign busy      = r_busy;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Randomized bench for freq_div_ctrl against a period-level reference model.
// Covers FREQ_DIV_CTRL_CNT_EN when the macro is defined for the build.
module tb_freq_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_div = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic        clk_out;
  logic        tick;
  logic        busy;
`ifdef FREQ_DIV_CTRL_CNT_EN
  logic [15:0] period_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  freq_div_ctrl #(.WIDTH(32), .DEFAULT_DIV(2)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick),
`ifdef FREQ_DIV_CTRL_CNT_EN
    .period_cnt(period_cnt),
`endif
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the divider is idle, running a period, or in its single stop cycle
  bit mRunning, mStopping, mHasPend, mErr;
  int mPos, mRatio, mPendVal, mPeriods;

  function automatic bit expClk();
    return mRunning && (mPos < (mRatio + 1) / 2);
  endfunction

  function automatic bit expTick();
    return mRunning && (mPos == 0);
  endfunction

  task automatic modelReset();
    mRunning = 0; mStopping = 0; mHasPend = 0; mErr = 0;
    mPos = 0; mRatio = 2; mPendVal = 0; mPeriods = 0;
  endtask

  task automatic modelStep(input bit r, input bit e, input bit v, input int d);
    bit accept, good, oldPend;
    if (r) begin
      modelReset();
      return;
    end
    if (expTick()) mPeriods = (mPeriods + 1) % 65536;
    accept  = v && !mHasPend;
    good    = (d >= 2);
    oldPend = mHasPend;
    mErr    = accept && !good;
    if (mRunning) begin
      if (mPos == mRatio - 1) begin
        if (e) begin
          mPos = 0;
          if (oldPend) begin mRatio = mPendVal; mHasPend = 0; end
        end else begin
          mRunning = 0; mStopping = 1;
        end
      end else begin
        mPos++;
      end
      if (accept && good) begin mHasPend = 1; mPendVal = d; end
    end else if (mStopping) begin
      mStopping = 0;
      if (mHasPend) begin mRatio = mPendVal; mHasPend = 0; end
      if (accept && good) mRatio = d;
    end else begin
      if (accept && good) mRatio = d;
      if (e) begin mRunning = 1; mPos = 0; end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("clk_out", 32'(clk_out), 32'(expClk()));
    checkOutput("tick", 32'(tick), 32'(expTick()));
    checkOutput("busy", 32'(busy), 32'(mRunning || mStopping));
    checkOutput("cfg_ready", 32'(cfg_ready), 32'(!mHasPend));
    checkOutput("cfg_err", 32'(cfg_err), 32'(mErr));
`ifdef FREQ_DIV_CTRL_CNT_EN
    checkOutput("period_cnt", 32'(period_cnt), 32'(mPeriods));
`endif
  endtask

  // Drives one cycle of inputs, advances the model on the edge, checks at the falling edge
  task automatic applyStimulus(input bit r, input bit e, input bit v, input int d);
    rst = r; en = e; cfg_valid = v; cfg_div = 32'(d);
    @(posedge clk_in);
    modelStep(r, e, v, d);
    @(negedge clk_in);
    checkAll();
  endtask

  initial begin
    bit curEn;
    modelReset();
    @(negedge clk_in);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Default ratio, then an IDLE write of 5
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 5);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);

    // Mid-period write of 7 while running 5, then bad ratios 1 and 0
    applyStimulus(0, 1, 1, 7);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);

    // Reset while running with a pending ratio, then re-enable
    applyStimulus(0, 1, 1, 3);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    curEn = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, v;
      int d;
      if ($urandom_range(0, 19) == 0) curEn = ~curEn;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 5) == 0);
      d = $urandom_range(0, 9);
      applyStimulus(r, curEn, v, d);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
